rc_vc_stage: RTL and testbench

- Registered, per-virtual-channel route-computation stage for the 2D-mesh NoC router.
- Sits between the input VC buffers and the VC allocator.
- Latches a route for each head flit, presents it with a valid/ready handshake, and holds it for the whole packet until the tail departs.
- Generalises the combinational 5-port route calculator: VC count, mesh bounds and routing algorithm are parameters; per-channel state, out-of-range detection and error reporting are added.

---
 rtl/rc_pkg.sv | 24 ++
 rtl/route_calc_dor.sv | 45 ++++
 rtl/rc_vc_stage.sv | 135 +++++++++++++
 tb/tb_rc_vc_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rc_pkg.sv
// Shared types and constants for the per-VC route-computation stage.
package rc_pkg;

    typedef logic [2:0] dir_t;

    localparam dir_t LOCAL = 3'd0;
    localparam dir_t NORTH = 3'd1;
    localparam dir_t EAST  = 3'd2;
    localparam dir_t SOUTH = 3'd3;
    localparam dir_t WEST  = 3'd4;

    localparam int unsigned NUM_DIR = 5;
    localparam int unsigned CNT_W   = 16;

    localparam int unsigned ALGO_XY = 0;
    localparam int unsigned ALGO_YX = 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACTIVE
    } state_e;

endpackage

// File: rtl/route_calc_dor.sv
// Combinational dimension-order route lookup (XY or YX) with mesh bound check.
module route_calc_dor
    import rc_pkg::*;
#(
    parameter int unsigned X_WIDTH = 2,
    parameter int unsigned Y_WIDTH = 2,
    parameter int unsigned MESH_X  = 4,
    parameter int unsigned MESH_Y  = 4
) (
    input  logic [X_WIDTH-1:0] id_x,
    input  logic [Y_WIDTH-1:0] id_y,
    input  logic [X_WIDTH-1:0] dst_x,
    input  logic [Y_WIDTH-1:0] dst_y,
    input  logic               algo,
    output dir_t               dir,
    output logic               oor
);

    logic x_gt, x_lt, y_gt, y_lt;

    assign x_gt = dst_x > id_x;
    assign x_lt = dst_x < id_x;
    assign y_gt = dst_y > id_y;
    assign y_lt = dst_y < id_y;

    // Out-of-range destinations are steered to the local port for discard.
    always_comb begin
        oor = (32'(dst_x) >= MESH_X) || (32'(dst_y) >= MESH_Y);
        dir = LOCAL;
        if (!oor) begin
            if (algo) begin
                if (y_gt)      dir = SOUTH;
                else if (y_lt) dir = NORTH;
                else if (x_gt) dir = EAST;
                else if (x_lt) dir = WEST;
            end else begin
                if (x_gt)      dir = EAST;
                else if (x_lt) dir = WEST;
                else if (y_gt) dir = SOUTH;
                else if (y_lt) dir = NORTH;
            end
        end
    end

endmodule

// File: rtl/rc_vc_stage.sv
// Registered per-VC route-computation stage; RC_STATS_EN adds per-direction handshake counters (rt_cnt).
module rc_vc_stage
    import rc_pkg::*;
#(
    parameter int unsigned X_WIDTH    = 2,
    parameter int unsigned Y_WIDTH    = 2,
    parameter int unsigned MESH_X     = 4,
    parameter int unsigned MESH_Y     = 4,
    parameter int unsigned NUM_VC     = 2,
    parameter int unsigned ROUTE_ALGO = ALGO_XY
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [X_WIDTH-1:0]                  id_x,
    input  logic [Y_WIDTH-1:0]                  id_y,
    input  logic [5*NUM_VC-1:0]                 hd_valid,
    output logic [5*NUM_VC-1:0]                 hd_ready,
    input  logic [5*NUM_VC-1:0][X_WIDTH-1:0]    hd_dst_x,
    input  logic [5*NUM_VC-1:0][Y_WIDTH-1:0]    hd_dst_y,
    input  logic [5*NUM_VC-1:0]                 tail_done,
    output logic [5*NUM_VC-1:0]                 rt_valid,
    input  logic [5*NUM_VC-1:0]                 rt_ready,
    output logic [5*NUM_VC-1:0][2:0]            rt_sel,
    output logic [5*NUM_VC-1:0]                 rt_err
`ifdef RC_STATS_EN
    ,
    output logic [NUM_DIR-1:0][CNT_W-1:0]       rt_cnt
`endif
);

    localparam int unsigned CH   = 5 * NUM_VC;
    localparam logic        ALGO = (ROUTE_ALGO == ALGO_YX);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        state_e             state_q, state_d;
        logic [X_WIDTH-1:0] dst_x_q, id_x_q;
        logic [Y_WIDTH-1:0] dst_y_q, id_y_q;
        logic               first_q, viol_q;
        logic               accept, viol;
        dir_t               dir;
        logic               oor;

        // Next-state logic; a tail outside ACTIVE is flagged but never moves the FSM.
        always_comb begin
            state_d = state_q;
            accept  = 1'b0;
            viol    = tail_done[c] && (state_q != ACTIVE);
            case (state_q)
                IDLE: begin
                    if (hd_valid[c]) begin
                        accept  = 1'b1;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (rt_ready[c]) state_d = ACTIVE;
                end
                ACTIVE: begin
                    if (tail_done[c]) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                dst_x_q <= '0;
                dst_y_q <= '0;
                id_x_q  <= '0;
                id_y_q  <= '0;
                first_q <= 1'b0;
                viol_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                first_q <= accept;
                viol_q  <= viol;
                if (accept) begin
                    dst_x_q <= hd_dst_x[c];
                    dst_y_q <= hd_dst_y[c];
                    id_x_q  <= id_x;
                    id_y_q  <= id_y;
                end
            end
        end

        route_calc_dor #(
            .X_WIDTH (X_WIDTH),
            .Y_WIDTH (Y_WIDTH),
            .MESH_X  (MESH_X),
            .MESH_Y  (MESH_Y)
        ) u_rc (
            .id_x  (id_x_q),
            .id_y  (id_y_q),
            .dst_x (dst_x_q),
            .dst_y (dst_y_q),
            .algo  (ALGO),
            .dir   (dir),
            .oor   (oor)
        );

        assign hd_ready[c] = (state_q == IDLE);
        assign rt_valid[c] = (state_q == REQ);
        assign rt_sel[c]   = dir;
        assign rt_err[c]   = viol_q | (first_q & oor);
    end

`ifdef RC_STATS_EN
    logic [NUM_DIR-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_DIR-1:0][31:0]      sum;

    // Popcount of same-cycle handshakes per direction, saturating.
    always_comb begin
        sum   = '0;
        cnt_d = '0;
        for (int d = 0; d < NUM_DIR; d++) begin
            sum[d] = 32'(cnt_q[d]);
            for (int c = 0; c < CH; c++) begin
                if (rt_valid[c] && rt_ready[c] && (rt_sel[c] == 3'(d))) begin
                    sum[d] = sum[d] + 32'd1;
                end
            end
            cnt_d[d] = (sum[d] > 32'h0000_FFFF) ? 16'hFFFF : sum[d][CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign rt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rc_vc_stage.sv
// Randomized self-checking bench for rc_vc_stage: XY 4x4, YX 4x4 and XY 3x3 instances share one stimulus stream.
module tb_rc_vc_stage;

    localparam int CH   = 10;
    localparam int NDUT = 3;

    logic clk;
    logic rst;
    logic [1:0] id_x, id_y;
    logic [CH-1:0] hd_valid, tail_done, rt_ready;
    logic [CH-1:0][1:0] dst_x, dst_y;

    logic [CH-1:0]      hd_ready_o [NDUT];
    logic [CH-1:0]      rt_valid_o [NDUT];
    logic [CH-1:0][2:0] rt_sel_o   [NDUT];
    logic [CH-1:0]      rt_err_o   [NDUT];
`ifdef RC_STATS_EN
    logic [4:0][15:0]   rt_cnt_o   [NDUT];
`endif

    int algo_k [NDUT] = '{0, 1, 0};
    int mx_k   [NDUT] = '{4, 4, 3};
    int my_k   [NDUT] = '{4, 4, 3};

    // Behavioural model: per-channel phase, latched route per instance, pending error.
    int phase [CH];           // 0 waiting for head, 1 requesting, 2 packet in flight
    int msel  [NDUT][CH];
    bit merr  [NDUT][CH];
    int cnt_m [5];

    int nvec = 0;
    int nbad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rc_vc_stage #(.MESH_X(4), .MESH_Y(4), .ROUTE_ALGO(0)) u_xy (
        .clk(clk), .rst(rst), .id_x(id_x), .id_y(id_y),
        .hd_valid(hd_valid), .hd_ready(hd_ready_o[0]), .hd_dst_x(dst_x), .hd_dst_y(dst_y),
        .tail_done(tail_done), .rt_valid(rt_valid_o[0]), .rt_ready(rt_ready),
        .rt_sel(rt_sel_o[0]), .rt_err(rt_err_o[0])
`ifdef RC_STATS_EN
        , .rt_cnt(rt_cnt_o[0])
`endif
    );

    rc_vc_stage #(.MESH_X(4), .MESH_Y(4), .ROUTE_ALGO(1)) u_yx (
        .clk(clk), .rst(rst), .id_x(id_x), .id_y(id_y),
        .hd_valid(hd_valid), .hd_ready(hd_ready_o[1]), .hd_dst_x(dst_x), .hd_dst_y(dst_y),
        .tail_done(tail_done), .rt_valid(rt_valid_o[1]), .rt_ready(rt_ready),
        .rt_sel(rt_sel_o[1]), .rt_err(rt_err_o[1])
`ifdef RC_STATS_EN
        , .rt_cnt(rt_cnt_o[1])
`endif
    );

    rc_vc_stage #(.MESH_X(3), .MESH_Y(3), .ROUTE_ALGO(0)) u_m3 (
        .clk(clk), .rst(rst), .id_x(id_x), .id_y(id_y),
        .hd_valid(hd_valid), .hd_ready(hd_ready_o[2]), .hd_dst_x(dst_x), .hd_dst_y(dst_y),
        .tail_done(tail_done), .rt_valid(rt_valid_o[2]), .rt_ready(rt_ready),
        .rt_sel(rt_sel_o[2]), .rt_err(rt_err_o[2])
`ifdef RC_STATS_EN
        , .rt_cnt(rt_cnt_o[2])
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%h want=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Dimension-order route from the textual rules; out-of-mesh goes LOCAL.
    function automatic int route(int algo, int ix, int iy, int dx, int dy, int mx, int my);
        if (dx >= mx || dy >= my) return 0;
        if (algo == 0) begin
            if (dx > ix) return 2;
            if (dx < ix) return 4;
            if (dy > iy) return 3;
            if (dy < iy) return 1;
        end else begin
            if (dy > iy) return 3;
            if (dy < iy) return 1;
            if (dx > ix) return 2;
            if (dx < ix) return 4;
        end
        return 0;
    endfunction

    task automatic model_step();
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                phase[c] = 0;
                for (int k = 0; k < NDUT; k++) begin
                    msel[k][c] = 0;
                    merr[k][c] = 0;
                end
            end
            for (int d = 0; d < 5; d++) cnt_m[d] = 0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < NDUT; k++) merr[k][c] = tail_done[c] && (phase[c] != 2);
                if (phase[c] == 0 && hd_valid[c]) begin
                    for (int k = 0; k < NDUT; k++) begin
                        msel[k][c] = route(algo_k[k], int'(id_x), int'(id_y),
                                           int'(dst_x[c]), int'(dst_y[c]), mx_k[k], my_k[k]);
                        if (int'(dst_x[c]) >= mx_k[k] || int'(dst_y[c]) >= my_k[k]) merr[k][c] = 1;
                    end
                    phase[c] = 1;
                end else if (phase[c] == 1 && rt_ready[c]) begin
                    if (cnt_m[msel[0][c]] < 65535) cnt_m[msel[0][c]]++;
                    phase[c] = 2;
                end else if (phase[c] == 2 && tail_done[c]) begin
                    phase[c] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [CH-1:0]      e_rdy, e_val, e_err;
        logic [CH-1:0][2:0] e_sel;
        for (int k = 0; k < NDUT; k++) begin
            for (int c = 0; c < CH; c++) begin
                e_rdy[c] = (phase[c] == 0);
                e_val[c] = (phase[c] == 1);
                e_err[c] = merr[k][c];
                e_sel[c] = 3'(msel[k][c]);
            end
            check_eq($sformatf("hd_ready[dut%0d]", k), 64'(hd_ready_o[k]), 64'(e_rdy));
            check_eq($sformatf("rt_valid[dut%0d]", k), 64'(rt_valid_o[k]), 64'(e_val));
            check_eq($sformatf("rt_sel[dut%0d]", k),   64'(rt_sel_o[k]),   64'(e_sel));
            check_eq($sformatf("rt_err[dut%0d]", k),   64'(rt_err_o[k]),   64'(e_err));
        end
`ifdef RC_STATS_EN
        for (int d = 0; d < 5; d++) begin
            check_eq($sformatf("rt_cnt[%0d]", d), 64'(rt_cnt_o[0][d]), 64'(cnt_m[d]));
        end
`endif
    endtask

    // Drive one cycle of inputs, advance the model, then compare on the falling edge.
    task automatic apply(input bit rs, input logic [CH-1:0] v, input logic [CH-1:0] r,
                         input logic [CH-1:0] t);
        rst       = rs;
        hd_valid  = v;
        rt_ready  = r;
        tail_done = t;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        id_x = 2'd1;
        id_y = 2'd1;
        hd_valid = '0;
        rt_ready = '0;
        tail_done = '0;
        for (int c = 0; c < CH; c++) begin
            dst_x[c] = 2'd1;
            dst_y[c] = 2'd1;
        end

        apply(1, '0, '0, '0);
        apply(1, '0, '0, '0);
        apply(0, '0, '0, '0);

        // ch0 head to (3,0): EAST under XY, NORTH under YX, out of range in the 3x3 mesh
        dst_x[0] = 2'd3;
        dst_y[0] = 2'd0;
        apply(0, CH'(1), '0, '0);
        dst_x[0] = 2'd1;
        dst_y[0] = 2'd1;
        for (int i = 0; i < 3; i++) apply(0, '0, '0, '0);
        apply(0, '0, CH'(1), '0);

        // tail on an idle channel, then tail together with a held head on ch0
        apply(0, '0, '0, CH'(2));
        apply(0, CH'(1), '0, CH'(1));
        apply(0, CH'(1), '0, '0);
        apply(0, '0, CH'(1), '0);

        // reset while ch0 is in flight
        apply(1, '0, '0, '0);
        apply(0, '0, '0, '0);

        // every channel takes a head at once; ch2..4 head EAST
        for (int c = 0; c < CH; c++) begin
            dst_x[c] = 2'($urandom_range(0, 3));
            dst_y[c] = 2'($urandom_range(0, 3));
        end
        for (int c = 2; c < 5; c++) begin
            dst_x[c] = 2'd3;
            dst_y[c] = 2'd2;
        end
        apply(0, '1, '0, '0);
        apply(0, '0, '1, '0);
        apply(0, '0, '0, '1);

        // randomized traffic with occasional resets and router-id changes
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < CH; c++) begin
                dst_x[c] = 2'($urandom_range(0, 3));
                dst_y[c] = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 99) == 0) begin
                id_x = 2'($urandom_range(0, 3));
                id_y = 2'($urandom_range(0, 3));
            end
            apply(($urandom_range(0, 199) == 0), CH'($urandom), CH'($urandom),
                  CH'($urandom) & CH'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
